// File: rtl/axi_lite_pkg.sv
// Shared definitions for the core-to-AXI4-Lite peripheral bridge:
// response codes, protection default and the bridge FSM state type.
package axi_lite_pkg;

    localparam int unsigned RESP_WIDTH = 2;
    localparam int unsigned PROT_WIDTH = 3;

    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_WIDTH-1:0] RESP_DECERR = 2'b11;

    localparam logic [PROT_WIDTH-1:0] PROT_NONE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_LOCAL_ERR,
        ST_DONE
    } bridge_state_e;

    // Slave and decode errors both report as a failed access to the core.
    function automatic logic resp_is_err(input logic [RESP_WIDTH-1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_core_bridge.sv
// Single-outstanding core data port to AXI4-Lite master bridge; addresses
// outside the peripheral window complete locally with an error.
module axi_lite_core_bridge
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE = ADDR_WIDTH'(32'h1A10_0000),
    parameter logic [ADDR_WIDTH-1:0] PERIPH_MASK = ADDR_WIDTH'(32'hFFFF_0000),
    localparam int unsigned          STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk_50_mhz,
    input  logic                  rst,

    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [STRB_WIDTH-1:0] core_be,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_err,

    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [PROT_WIDTH-1:0] awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [RESP_WIDTH-1:0] bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [PROT_WIDTH-1:0] arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [RESP_WIDTH-1:0] rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    bridge_state_e         state_q;
    bridge_state_e         state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] be_q;

    logic [ADDR_WIDTH-1:0] addr_align_c;
    logic                  win_hit_c;
    logic                  aw_done_c;
    logic                  w_done_c;

    logic                  awvalid_d;
    logic                  wvalid_d;
    logic                  bready_d;
    logic                  arvalid_d;
    logic                  rready_d;
    logic                  core_rvalid_d;
    logic                  core_err_d;
    logic [DATA_WIDTH-1:0] core_rdata_d;

    assign addr_align_c = core_addr & ~ALIGN_MASK;
    assign win_hit_c    = (addr_align_c & PERIPH_MASK) == PERIPH_BASE;

    // Grant is the only combinational output: accepted in the same cycle as req.
    assign core_gnt = (state_q == ST_IDLE) && core_req && !rst;

    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = be_q;
    assign awprot = PROT_NONE;
    assign arprot = PROT_NONE;

    // A channel is done once its valid has dropped or is handshaking this cycle.
    assign aw_done_c = !awvalid || awready;
    assign w_done_c  = !wvalid || wready;

    // Next-state and next-output decode.
    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid;
        wvalid_d      = wvalid;
        bready_d      = bready;
        arvalid_d     = arvalid;
        rready_d      = rready;
        core_rvalid_d = 1'b0;
        core_err_d    = 1'b0;
        core_rdata_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (core_gnt) begin
                    if (!win_hit_c) begin
                        state_d = ST_LOCAL_ERR;
                    end else if (core_we) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                awvalid_d = awvalid && !awready;
                wvalid_d  = wvalid && !wready;
                if (aw_done_c && w_done_c) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    state_d       = ST_DONE;
                    bready_d      = 1'b0;
                    core_rvalid_d = 1'b1;
                    core_err_d    = resp_is_err(bresp);
                end
            end
            ST_RD_ADDR: begin
                if (arready) begin
                    state_d   = ST_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (rvalid) begin
                    state_d       = ST_DONE;
                    rready_d      = 1'b0;
                    core_rvalid_d = 1'b1;
                    core_rdata_d  = rdata;
                    core_err_d    = resp_is_err(rresp);
                end
            end
            ST_LOCAL_ERR: begin
                state_d       = ST_DONE;
                core_rvalid_d = 1'b1;
                core_err_d    = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk_50_mhz) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            core_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            awvalid     <= awvalid_d;
            wvalid      <= wvalid_d;
            bready      <= bready_d;
            arvalid     <= arvalid_d;
            rready      <= rready_d;
            core_rvalid <= core_rvalid_d;
            core_rdata  <= core_rdata_d;
            core_err    <= core_err_d;
            if (core_gnt) begin
                addr_q  <= addr_align_c;
                wdata_q <= core_wdata;
                be_q    <= core_be;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_core_bridge.sv
// Bench for axi_lite_core_bridge: reactive AXI4-Lite slave, transaction-level
// timing model and a per-cycle compare of every bridge output.
`timescale 1ns/1ps
module tb_axi_lite_core_bridge;

    localparam logic [31:0] BASE = 32'h1A10_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic        clk_50_mhz = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_gnt, core_rvalid, core_err;
    logic [3:0]  core_be;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #10 clk_50_mhz = ~clk_50_mhz;

    axi_lite_core_bridge dut (
        .clk_50_mhz (clk_50_mhz), .rst (rst),
        .core_req (core_req), .core_we (core_we), .core_be (core_be),
        .core_addr (core_addr), .core_wdata (core_wdata), .core_gnt (core_gnt),
        .core_rvalid (core_rvalid), .core_rdata (core_rdata), .core_err (core_err),
        .awaddr (awaddr), .awprot (awprot), .awvalid (awvalid), .awready (awready),
        .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid), .wready (wready),
        .bresp (bresp), .bvalid (bvalid), .bready (bready),
        .araddr (araddr), .arprot (arprot), .arvalid (arvalid), .arready (arready),
        .rdata (rdata), .rresp (rresp), .rvalid (rvalid), .rready (rready)
    );

    int cyc = 0;
    always @(posedge clk_50_mhz) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    // Current transaction as seen by the model.
    logic        t_active = 1'b0;
    int          t_g;
    logic        t_we, t_hit;
    logic [31:0] t_addr, t_wdata, t_rdat;
    logic [3:0]  t_be;
    int          t_awd, t_wd, t_bd, t_ard, t_rd;
    logic [1:0]  t_resp;

    // Observations of the DUT, cleared per transaction.
    int          rv_count, rv_cyc, n_aw, n_w, n_b, n_ar, n_r;
    logic [31:0] obs_rdata, obs_awaddr, obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Cycle offset (from grant) at which core_rvalid must pulse.
    function automatic int done_off();
        if (!t_hit) return 2;
        if (t_we)   return 3 + ((t_awd > t_wd) ? t_awd : t_wd) + t_bd;
        return 3 + t_ard + t_rd;
    endfunction

    always @(negedge clk_50_mhz) begin : compare
        int          o, m, e;
        logic        e_gnt, e_aw, e_w, e_b, e_ar, e_r, e_rv, e_err;
        logic [31:0] e_rdata;
        if (chk_en) begin
            e_gnt = 0; e_aw = 0; e_w = 0; e_b = 0; e_ar = 0; e_r = 0; e_rv = 0; e_err = 0;
            e_rdata = '0;
            if (t_active) begin
                o       = cyc - t_g;
                e       = done_off();
                m       = (t_awd > t_wd) ? t_awd : t_wd;
                e_gnt   = (o == 0);
                e_rv    = (o == e);
                e_err   = !t_hit || (t_resp != 2'b00);
                e_rdata = (t_hit && !t_we) ? t_rdat : 32'h0;
                if (t_hit && t_we) begin
                    e_aw = (o >= 1) && (o <= 1 + t_awd);
                    e_w  = (o >= 1) && (o <= 1 + t_wd);
                    e_b  = (o >= 2 + m) && (o <= 2 + m + t_bd);
                end else if (t_hit) begin
                    e_ar = (o >= 1) && (o <= 1 + t_ard);
                    e_r  = (o >= 2 + t_ard) && (o <= 2 + t_ard + t_rd);
                end
            end
            chk("core_gnt",    32'(core_gnt),    32'(e_gnt));
            chk("core_rvalid", 32'(core_rvalid), 32'(e_rv));
            chk("awvalid",     32'(awvalid),     32'(e_aw));
            chk("wvalid",      32'(wvalid),      32'(e_w));
            chk("bready",      32'(bready),      32'(e_b));
            chk("arvalid",     32'(arvalid),     32'(e_ar));
            chk("rready",      32'(rready),      32'(e_r));
            if (e_rv) begin
                chk("core_rdata", core_rdata,    e_rdata);
                chk("core_err",   32'(core_err), 32'(e_err));
            end
            if (e_aw) begin
                chk("awaddr", awaddr, t_addr & ~32'h3);
                chk("awprot", 32'(awprot), 32'h0);
            end
            if (e_w) begin
                chk("wdata", wdata, t_wdata);
                chk("wstrb", 32'(wstrb), 32'(t_be));
            end
            if (e_ar) begin
                chk("araddr", araddr, t_addr & ~32'h3);
                chk("arprot", 32'(arprot), 32'h0);
            end
            if (core_rvalid) begin
                rv_count++; rv_cyc = cyc; obs_rdata = core_rdata; obs_err = core_err;
            end
            if (awvalid) begin
                if (n_aw == 0) obs_awaddr = awaddr;
                n_aw++;
            end
            if (wvalid) begin
                if (n_w == 0) begin obs_wdata = wdata; obs_wstrb = wstrb; end
                n_w++;
            end
            if (bready)  n_b++;
            if (arvalid) n_ar++;
            if (rready)  n_r++;
        end
    end

    task automatic clear_obs();
        rv_count = 0; rv_cyc = -100; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        obs_rdata = '0; obs_awaddr = '0; obs_wdata = '0; obs_wstrb = '0; obs_err = 1'b0;
    endtask

    task automatic advance();
        @(posedge clk_50_mhz);
        #2;
    endtask

    // Gap cycles: bridge idle, slave drives junk that must be ignored.
    task automatic idle_cycles(input int n);
        t_active = 1'b0;
        core_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            awready = 1'($urandom_range(0, 1)); wready  = 1'($urandom_range(0, 1));
            arready = 1'($urandom_range(0, 1)); bvalid  = 1'($urandom_range(0, 1));
            rvalid  = 1'($urandom_range(0, 1)); bresp   = 2'($urandom());
            rresp   = 2'($urandom());           rdata   = $urandom();
            advance();
        end
    endtask

    // Issue one request and play the slave for it; abort_at >= 0 asserts rst in that cycle.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd_v,
                          input logic [3:0] be, input int awd, input int wd, input int bd,
                          input int ard, input int rd, input logic [1:0] resp,
                          input logic [31:0] rdat, input int abort_at);
        int e, aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        clear_obs();
        t_we = we; t_addr = addr; t_wdata = wd_v; t_be = be; t_rdat = rdat; t_resp = resp;
        t_awd = awd; t_wd = wd; t_bd = bd; t_ard = ard; t_rd = rd;
        t_hit = ((addr & MASK) == BASE);
        t_g = cyc;
        t_active = 1'b1;
        e = done_off();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd_v; core_be = be;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        for (int o = 0; o <= e; o++) begin
            if (o > 0) begin
                core_req   = 1'($urandom_range(0, 1));
                core_we    = 1'($urandom_range(0, 1));
                core_addr  = $urandom();
                core_wdata = $urandom();
                core_be    = 4'($urandom());
                if (awvalid) begin awready = (aw_cnt >= awd); aw_cnt++; end
                else awready = 1'($urandom_range(0, 1));
                if (wvalid) begin wready = (w_cnt >= wd); w_cnt++; end
                else wready = 1'($urandom_range(0, 1));
                if (arvalid) begin arready = (ar_cnt >= ard); ar_cnt++; end
                else arready = 1'($urandom_range(0, 1));
                if (bready) begin bvalid = (b_cnt >= bd); b_cnt++; end
                else bvalid = 1'($urandom_range(0, 1));
                bresp = (bready && bvalid) ? resp : 2'($urandom());
                if (rready) begin rvalid = (r_cnt >= rd); r_cnt++; end
                else rvalid = 1'($urandom_range(0, 1));
                rdata = (rready && rvalid) ? rdat : $urandom();
                rresp = (rready && rvalid) ? resp : 2'($urandom());
            end
            if (o == abort_at) rst = 1'b1;
            advance();
            if (o == abort_at) begin
                t_active = 1'b0;
                break;
            end
        end
        core_req = 1'b0;
    endtask

    initial begin
        logic        r_we;
        logic [31:0] r_addr;
        logic [1:0]  r_resp;
        rst = 1'b1; core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        clear_obs();
        advance();
        chk_en   = 1'b1;
        core_req = 1'b1;
        core_addr = BASE;
        repeat (2) advance();
        rst = 1'b0;
        idle_cycles(2);

        // Zero-wait write of one byte.
        do_txn(1'b1, 32'h1A10_0004, 32'h0000_00A5, 4'h1, 0, 0, 0, 0, 0, 2'b00, 32'h0, -1);
        chk("d1_latency", 32'(rv_cyc - t_g), 32'd3);
        chk("d1_awaddr",  obs_awaddr, 32'h1A10_0004);
        chk("d1_wstrb",   32'(obs_wstrb), 32'h1);
        chk("d1_wdata",   obs_wdata, 32'h0000_00A5);
        chk("d1_err",     32'(obs_err), 32'h0);
        chk("d1_rdata",   obs_rdata, 32'h0);
        idle_cycles(1);

        // Read with a four-cycle arready stall.
        do_txn(1'b0, 32'h1A10_1000, 32'h0, 4'h0, 0, 0, 0, 4, 0, 2'b00, 32'hDEAD_BEEF, -1);
        chk("d2_latency", 32'(rv_cyc - t_g), 32'd7);
        chk("d2_ar_cycles", 32'(n_ar), 32'd5);
        chk("d2_rdata",   obs_rdata, 32'hDEAD_BEEF);
        chk("d2_err",     32'(obs_err), 32'h0);

        // wready two cycles ahead of awready.
        do_txn(1'b1, 32'h1A10_0010, 32'h1234_5678, 4'hF, 2, 0, 0, 0, 0, 2'b00, 32'h0, -1);
        chk("d3_w_cycles",  32'(n_w), 32'd1);
        chk("d3_aw_cycles", 32'(n_aw), 32'd3);
        chk("d3_b_cycles",  32'(n_b), 32'd1);
        chk("d3_rv_count",  32'(rv_count), 32'd1);
        chk("d3_latency",   32'(rv_cyc - t_g), 32'd5);

        // Out-of-window read answered locally.
        do_txn(1'b0, 32'h0000_8000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h5555_AAAA, -1);
        chk("d4_ar_cycles", 32'(n_ar), 32'd0);
        chk("d4_latency",   32'(rv_cyc - t_g), 32'd2);
        chk("d4_err",       32'(obs_err), 32'h1);
        chk("d4_rdata",     obs_rdata, 32'h0);

        // Slave error on an unaligned write address.
        do_txn(1'b1, 32'h1A10_0107, 32'hCAFE_F00D, 4'h6, 0, 1, 2, 0, 0, 2'b10, 32'h0, -1);
        chk("d5_awaddr", obs_awaddr, 32'h1A10_0104);
        chk("d5_err",    32'(obs_err), 32'h1);
        chk("d5_latency", 32'(rv_cyc - t_g), 32'd6);

        // Reset while waiting for read data, then a normal read.
        do_txn(1'b0, 32'h1A10_0200, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b00, 32'h0BAD_0BAD, 3);
        core_req = 1'b1;
        advance();
        rst = 1'b0;
        idle_cycles(3);
        chk("d6_no_rvalid", 32'(rv_count), 32'd0);
        do_txn(1'b0, 32'h1A10_0300, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0102_0304, -1);
        chk("d6_latency", 32'(rv_cyc - t_g), 32'd3);
        chk("d6_rdata",   obs_rdata, 32'h0102_0304);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                r_addr = BASE | {16'h0, 16'($urandom())};
            end else begin
                r_addr = $urandom();
                if ((r_addr & MASK) == BASE) r_addr = r_addr ^ 32'h8000_0000;
            end
            case ($urandom_range(0, 3))
                0, 1:    r_resp = 2'b00;
                2:       r_resp = 2'b10;
                default: r_resp = 2'b11;
            endcase
            do_txn(r_we, r_addr, $urandom(), 4'($urandom()),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), r_resp, $urandom(), -1);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
